// File: rtl/syn_pipe_reg_pkg.sv
// Shared constants for pipeline stage registers and profiling counters.
// Counter select codes, counter width and saturation limit.
package syn_pipe_reg_pkg;

  localparam int          PIPE_CTR_BIT = 32;
  localparam logic [31:0] PIPE_CTR_MAX = 32'hFFFF_FFFF;

  localparam logic [1:0] PIPE_CTR_CYC   = 2'd0;
  localparam logic [1:0] PIPE_CTR_STALL = 2'd1;
  localparam logic [1:0] PIPE_CTR_FLUSH = 2'd2;
  localparam logic [1:0] PIPE_CTR_PASS  = 2'd3;

  typedef struct packed {
    logic cyc;
    logic stall;
    logic flush;
    logic pass;
  } pipe_evt_t;

endpackage

// File: rtl/syn_perf_ctr.sv
// Saturating event counter for pipeline profiling.
// Synchronous clear has priority over increment; no wrap at the top.
module syn_perf_ctr
  import syn_pipe_reg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [PIPE_CTR_BIT-1:0] count
);

  // clear wins; otherwise count up until the ceiling
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != PIPE_CTR_MAX)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/syn_pipe_reg.sv
// Pipeline stage register with hold (en) and bubble insert (nop).
// Define PIPE_PERF_EN to build the stall/flush profiling counters.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module syn_pipe_reg
  import syn_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int PC_W   = `IM_ADDR_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              nop,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  input  logic [1:0]        ctr_sel,
  input  logic              ctr_clr,
  output logic [31:0]       ctr_val
);

  // stage contents: bubble beats load, load beats hold
  always_ff @(posedge clk) begin
    if (rst || nop) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_data  <= in_data;
    end
  end

`ifdef PIPE_PERF_EN
  pipe_evt_t         evt;
  logic [31:0]       cnt_cyc;
  logic [31:0]       cnt_stall;
  logic [31:0]       cnt_flush;
  logic [31:0]       cnt_pass;
  logic [31:0]       ctr_mux;

  // classify this cycle for the profiling counters
  always_comb begin
    evt       = '0;
    evt.cyc   = 1'b1;
    evt.stall = !nop && !en;
    evt.flush = nop && in_valid;
    evt.pass  = !nop && en && in_valid;
  end

  syn_perf_ctr u_cyc (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .inc   (evt.cyc),
    .count (cnt_cyc)
  );

  syn_perf_ctr u_stall (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .inc   (evt.stall),
    .count (cnt_stall)
  );

  syn_perf_ctr u_flush (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .inc   (evt.flush),
    .count (cnt_flush)
  );

  syn_perf_ctr u_pass (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .inc   (evt.pass),
    .count (cnt_pass)
  );

  // pick the counter addressed by ctr_sel
  always_comb begin
    ctr_mux = '0;
    unique case (ctr_sel)
      PIPE_CTR_CYC:   ctr_mux = cnt_cyc;
      PIPE_CTR_STALL: ctr_mux = cnt_stall;
      PIPE_CTR_FLUSH: ctr_mux = cnt_flush;
      PIPE_CTR_PASS:  ctr_mux = cnt_pass;
      default:        ctr_mux = '0;
    endcase
  end

  // read port sees pre-increment value, one cycle late
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_val <= '0;
    end else begin
      ctr_val <= ctr_mux;
    end
  end
`else
  logic unused_ctr;

  assign unused_ctr = ^{ctr_sel, ctr_clr};
  assign ctr_val    = '0;
`endif

endmodule

// File: tb/tb_syn_pipe_reg.sv
// Directed self-checking bench for syn_pipe_reg.
// Counter expectations collapse to 0 when PIPE_PERF_EN is undefined.
`timescale 1ns/1ps

module tb_syn_pipe_reg;

  localparam int DATA_W = 64;
  localparam int PC_W   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              nop;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        ctr_sel;
  logic              ctr_clr;
  logic [31:0]       ctr_val;

  int checks = 0;
  int errors = 0;

  syn_pipe_reg #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .nop       (nop),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .ctr_sel   (ctr_sel),
    .ctr_clr   (ctr_clr),
    .ctr_val   (ctr_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pv(input logic [31:0] v);
`ifdef PIPE_PERF_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic n, input logic v,
                       input logic [PC_W-1:0] p, input logic [DATA_W-1:0] d);
    en       = e;
    nop      = n;
    in_valid = v;
    in_pc    = p;
    in_data  = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ctr_clr = 1'b0;
    ctr_sel = 2'd0;
    drive(1'b1, 1'b0, 1'b1, 10'h3FF, '1);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_pc !== 10'h000) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 000", out_pc);
    end
    checks++;
    if (out_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    checks++;
    if (ctr_val !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctr: got %h expected 0", ctr_val);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_stall;
    drive(1'b1, 1'b0, 1'b1, 10'h010, 64'hA5);
    ctr_clr = 1'b1;
    step();
    ctr_clr = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 10'h010 || out_data !== 64'hA5) begin
      errors++;
      $display("FAIL load: got %b/%h/%h expected 1/010/a5",
               out_valid, out_pc, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, i[0], 10'h100 + 10'(i), 64'hDEAD_0000 + 64'(i));
      if (i == 3) ctr_sel = 2'd1;
      if (i == 4) ctr_sel = 2'd0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 10'h010 || out_data !== 64'hA5) begin
        errors++;
        $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/010/a5",
                 i, out_valid, out_pc, out_data);
      end
      if (i == 3) begin
        checks++;
        if (ctr_val !== pv(32'd3)) begin
          errors++;
          $display("FAIL stall_count: got %0d expected %0d", ctr_val, pv(32'd3));
        end
      end
      if (i == 4) begin
        checks++;
        if (ctr_val !== pv(32'd4)) begin
          errors++;
          $display("FAIL cycle_count: got %0d expected %0d", ctr_val, pv(32'd4));
        end
      end
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b0, 1'b1, 1'b1, 10'h155, 64'h1234);
    ctr_sel = 2'd2;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 10'h000 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL flush_bubble: got %b/%h/%h expected 0/000/0",
               out_valid, out_pc, out_data);
    end
    checks++;
    if (ctr_val !== pv(32'd0)) begin
      errors++;
      $display("FAIL flush_pre: got %0d expected 0", ctr_val);
    end
    drive(1'b1, 1'b0, 1'b0, 10'h000, 64'h0);
    step();
    checks++;
    if (ctr_val !== pv(32'd1)) begin
      errors++;
      $display("FAIL flush_count: got %0d expected %0d", ctr_val, pv(32'd1));
    end
    ctr_sel = 2'd1;
    step();
    checks++;
    if (ctr_val !== pv(32'd5)) begin
      errors++;
      $display("FAIL flush_no_stall: got %0d expected %0d", ctr_val, pv(32'd5));
    end
    ctr_sel = 2'd2;
    drive(1'b1, 1'b1, 1'b0, 10'h0AA, 64'h55);
    step();
    drive(1'b1, 1'b1, 1'b1, 10'h0AB, 64'h56);
    step();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 10'h000 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL nop_en_bubble: got %b/%h/%h expected 0/000/0",
               out_valid, out_pc, out_data);
    end
    drive(1'b1, 1'b0, 1'b0, 10'h000, 64'h0);
    step();
    checks++;
    if (ctr_val !== pv(32'd2)) begin
      errors++;
      $display("FAIL flush_valid_only: got %0d expected %0d", ctr_val, pv(32'd2));
    end
  endtask

  task automatic test_saturation;
    logic [31:0] exp_v [0:5];
    exp_v[0] = 32'hFFFF_FFFE;
    exp_v[1] = 32'hFFFF_FFFF;
    exp_v[2] = 32'hFFFF_FFFF;
    exp_v[3] = 32'hFFFF_FFFF;
    exp_v[4] = 32'h0;
    exp_v[5] = 32'h1;
    drive(1'b0, 1'b0, 1'b0, 10'h000, 64'h0);
    ctr_sel = 2'd3;
    @(negedge clk);
`ifdef PIPE_PERF_EN
    force dut.u_pass.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_pass.count;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 10'h200 + 10'(i), 64'(i) + 64'h77);
      ctr_clr = (i == 3);
      step();
      checks++;
      if (ctr_val !== pv(exp_v[i])) begin
        errors++;
        $display("FAIL sat_read%0d: got %h expected %h", i, ctr_val, pv(exp_v[i]));
      end
    end
    ctr_clr = 1'b0;
    checks++;
    if (out_pc !== 10'h205 || out_data !== 64'h7C) begin
      errors++;
      $display("FAIL sat_datapath: got %h/%h expected 205/7c", out_pc, out_data);
    end
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, 1'b0, 1'b1, 10'h030, 64'h5A);
    step();
    drive(1'b0, 1'b0, 1'b1, 10'h031, 64'h5B);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 10'h000 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_stall: got %b/%h/%h expected 0/000/0",
               out_valid, out_pc, out_data);
    end
    checks++;
    if (ctr_val !== 32'h0) begin
      errors++;
      $display("FAIL rst_stall_ctr: got %h expected 0", ctr_val);
    end
    ctr_sel = 2'd0;
    drive(1'b1, 1'b0, 1'b1, 10'h020, 64'h77);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 10'h020 || out_data !== 64'h77) begin
      errors++;
      $display("FAIL rst_reload: got %b/%h/%h expected 1/020/77",
               out_valid, out_pc, out_data);
    end
    checks++;
    if (ctr_val !== 32'h0) begin
      errors++;
      $display("FAIL rst_cyc_pre: got %h expected 0", ctr_val);
    end
    step();
    checks++;
    if (ctr_val !== pv(32'd1)) begin
      errors++;
      $display("FAIL rst_cyc_post: got %h expected %h", ctr_val, pv(32'd1));
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, i[0], 10'h040 + 10'(4 * i), {32'hC0DE_0000, 32'(i)});
      step();
      checks++;
      if (out_valid !== i[0] || out_pc !== 10'h040 + 10'(4 * i) ||
          out_data !== {32'hC0DE_0000, 32'(i)}) begin
        errors++;
        $display("FAIL b2b%0d: got %b/%h/%h expected %b/%h/%h", i,
                 out_valid, out_pc, out_data, i[0],
                 10'h040 + 10'(4 * i), {32'hC0DE_0000, 32'(i)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_stall_flush();
    test_saturation();
    test_reset_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_pipe_reg.md
# syn_pipe_reg

Pipeline stage register that consumes the stall/flush controls produced by the combinational pipeline interface controller (`pc_en`, `ifid_en`/`ifid_nop`, `idex_en`/`idex_nop`). One instance sits between each pair of stages (IF/ID, ID/EX, EX/MA, …) and latches a valid bit, the stage PC and an opaque payload each cycle, honouring hold and bubble-insert requests. Optionally, it keeps saturating per-stage event counters for stall/flush profiling.

## Interface
Parameters:
- `DATA_W`, default 64: payload width in bits (control and data fields packed by the instantiating stage).
- `PC_W`, default `` `IM_ADDR_BIT ``: PC width.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  load enable; 0 = hold current contents (stall).
- `nop`  in  1  bubble insert; 1 = next contents become a NOP.
- `in_valid`  in  1  upstream slot holds a real instruction.
- `in_pc`  in  PC_W  upstream PC.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  registered valid.
- `out_pc`  out  PC_W  registered PC.
- `out_data`  out  DATA_W  registered payload.
- `ctr_sel`  in  2  counter select: 0 = cycles, 1 = stall, 2 = flush, 3 = pass.
- `ctr_clr`  in  1  clear all counters.
- `ctr_val`  out  32  selected counter value, registered.

## Operation
- Per-edge priority: `rst` > `nop` > `en` > hold.
  - `rst`: `out_valid`=0, `out_pc`=0, `out_data`=0, counters=0, `ctr_val`=0.
  - `nop`=1: `out_valid`=0, `out_pc`=0, `out_data`=0, regardless of `en`. The controller drives `ifid_en`=0 together with `ifid_nop`=1 when a stall and a flush coincide; the flush wins.
  - `nop`=0, `en`=1: load `in_valid`, `in_pc`, `in_data`.
  - `nop`=0, `en`=0: all outputs hold.
- An all-zero payload is the NOP encoding (no register-file write, no memory access, no halt). Stages must pack fields so that this holds.
- Counter events, evaluated on each non-reset edge:
  - cycle: every edge.
  - stall: `nop`=0 and `en`=0.
  - flush: `nop`=1 and `in_valid`=1 (instruction killed).
  - pass: `nop`=0, `en`=1, `in_valid`=1.
- Counters are 32-bit unsigned and saturate at 0xFFFF_FFFF with no wrap.
- `ctr_clr`=1 sets all counters to 0 on that edge. Clear beats a same-cycle increment: the value after the edge is 0, not 1.

## Timing
- Data path latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Outputs are purely registered, with no combinational path from inputs to outputs. This keeps the controller's combinational loop (controller → en/nop → stage outputs → controller) broken at this register.
- `ctr_val` is the value selected by `ctr_sel` at edge N and sampled at edge N. It reflects counter state before that edge's increment, so read latency is 1 cycle.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first load can occur on the edge after `rst` deasserts.
- `nop` held high for several cycles keeps inserting bubbles. The flush count increments only on cycles with `in_valid`=1.

## Configuration
- `PIPE_PERF_EN` defined: the counters, `ctr_sel`/`ctr_clr` handling and `ctr_val` register are built as described above.
- `PIPE_PERF_EN` undefined:
  - No counter logic is generated.
  - `ctr_val` is tied to 0.
  - `ctr_sel` and `ctr_clr` are ignored.
  - Port list is unchanged, and the data path behaviour is identical in both builds.

## Structure
- Shared package/header (`Core.vh`):
  - `PIPE_CTR_CYC`/`STALL`/`FLUSH`/`PASS` select constants (0–3).
  - `PIPE_CTR_BIT` = 32.
  - `PIPE_CTR_MAX` = 32'hFFFF_FFFF.
- Sub-module `syn_perf_ctr`: one saturating 32-bit counter with synchronous `clr` (priority) and `inc`. It is instantiated four times inside the `PIPE_PERF_EN` guard.

## Test plan
- Reset: drive `rst`=1 with `in_valid`=1, `in_pc`=0x3FF, `in_data`=all-ones → after the edge all outputs are 0 and `ctr_val`=0.
- Load then stall: load pc=0x010, valid=1, data=0xA5 with `en`=1, then `en`=0 for 3 cycles with changing inputs → outputs stay 0x010/0xA5/1. The stall counter reads 3.
- Coincident stall and flush: `en`=0, `nop`=1, `in_valid`=1 → `out_valid`=0, pc=0, data=0. Flush count +1, stall count unchanged.
- Saturation and clear: force the pass counter to 0xFFFF_FFFE, then 3 pass cycles → reads 0xFFFF_FFFF. Assert `ctr_clr` on a pass cycle → reads 0 on the next read.
- Reset mid-stall: hold `en`=0 with valid contents, pulse `rst` for 1 cycle, then `en`=1 with pc=0x020 → outputs are 0 after the reset edge and load 0x020 on the following edge.
- Macro off: rebuild without `PIPE_PERF_EN` and rerun scenario 2 → data path results identical, `ctr_val`=0 throughout.
